// File: rtl/mdu_sequencer_if.sv
// E-stage request/response bundle between the pipeline and the MDU sequencer.
// The pipeline (or bench) drives through master; the sequencer sits on slave.
interface mdu_sequencer_if;
  logic        MDU_i_Start;
  logic [2:0]  MDU_i_Op;
  logic        MDU_i_Cancel;
  logic [31:0] MDU_i_A;
  logic [31:0] MDU_i_B;
  logic        MDU_i_RdHi;
  logic        MDU_o_Busy;
  logic [31:0] MDU_o_Out;

  modport master (
    output MDU_i_Start, MDU_i_Op, MDU_i_Cancel, MDU_i_A, MDU_i_B, MDU_i_RdHi,
    input  MDU_o_Busy, MDU_o_Out
  );

  modport slave (
    input  MDU_i_Start, MDU_i_Op, MDU_i_Cancel, MDU_i_A, MDU_i_B, MDU_i_RdHi,
    output MDU_o_Busy, MDU_o_Out
  );
endinterface

// File: rtl/mdu_sequencer.sv
// HI/LO owner and multi-cycle MULT/DIV sequencer for the E stage.
// The result is precomputed at accept and held pending until the busy window closes.
//
// state | meaning
// IDLE  | no op in flight; accepts MULT/DIV/MTHI/MTLO
// BUSY  | op in flight; cnt_q counts remaining busy cycles, commit when it reaches 1
module mdu_sequencer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic           MDU_i_Clk,
  input  logic           MDU_i_nReset,
  mdu_sequencer_if.slave bus
);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        phi_q, phi_d, plo_q, plo_d;
  logic               pwr_q, pwr_d;

  logic               accept;
  logic [63:0]        prod_s, prod_u;
  logic               div_sgn;
  logic [31:0]        ua, ub, ub_safe, quo, rem, quo_fix, rem_fix;

  assign accept = bus.MDU_i_Start & ~bus.MDU_i_Cancel & (state_q == IDLE);

  // Signed product is the low 64 bits of the sign-extended multiply.
  assign prod_s = {{32{bus.MDU_i_A[31]}}, bus.MDU_i_A} * {{32{bus.MDU_i_B[31]}}, bus.MDU_i_B};
  assign prod_u = {32'd0, bus.MDU_i_A} * {32'd0, bus.MDU_i_B};

  // Signed divide on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  assign div_sgn = (bus.MDU_i_Op == OP_DIV);
  assign ua      = (div_sgn & bus.MDU_i_A[31]) ? -bus.MDU_i_A : bus.MDU_i_A;
  assign ub      = (div_sgn & bus.MDU_i_B[31]) ? -bus.MDU_i_B : bus.MDU_i_B;
  assign ub_safe = (ub == 32'd0) ? 32'd1 : ub;
  assign quo     = ua / ub_safe;
  assign rem     = ua % ub_safe;
  assign quo_fix = (div_sgn & (bus.MDU_i_A[31] ^ bus.MDU_i_B[31])) ? -quo : quo;
  assign rem_fix = (div_sgn & bus.MDU_i_A[31]) ? -rem : rem;

  always_ff @(posedge MDU_i_Clk or negedge MDU_i_nReset) begin
    if (!MDU_i_nReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.MDU_i_Op)
            OP_MULT, OP_MULTU: begin
              state_d = BUSY;
              cnt_d   = CNT_W'(MULT_LAT);
              pwr_d   = 1'b1;
              {phi_d, plo_d} = (bus.MDU_i_Op == OP_MULT) ? prod_s : prod_u;
            end
            OP_DIV, OP_DIVU: begin
              state_d = BUSY;
              cnt_d   = CNT_W'(DIV_LAT);
              pwr_d   = (bus.MDU_i_B != 32'd0);
              phi_d   = rem_fix;
              plo_d   = quo_fix;
            end
            OP_MTHI: hi_d = bus.MDU_i_A;
            OP_MTLO: lo_d = bus.MDU_i_A;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.MDU_o_Busy = (state_q == BUSY);
    bus.MDU_o_Out  = bus.MDU_i_RdHi ? hi_q : lo_q;
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table of single ops plus
// hand sequences for cancel-while-busy and reset mid-divide.
module tb_mdu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_sequencer_if bus();

  mdu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .MDU_i_Clk    (clk),
    .MDU_i_nReset (rst_n),
    .bus          (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [31:0] pre;
    int          exp_n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic cancel, input logic [31:0] pre,
                              input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.cancel = cancel; v.pre = pre;
    v.exp_n = exp_n; v.exp_hi = exp_hi; v.exp_lo = exp_lo;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // A legal pipeline never issues Start into a busy unit.
  always @(posedge clk) begin
    if (rst_n && bus.MDU_i_Start && !bus.MDU_i_Cancel && bus.MDU_o_Busy) begin
      errors++;
      $display("FAIL start_while_busy actual=1 required=0");
    end
  end

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.MDU_i_RdHi = 1'b1;
    #1 hi = bus.MDU_o_Out;
    bus.MDU_i_RdHi = 1'b0;
    #1 lo = bus.MDU_o_Out;
    bus.MDU_i_RdHi = 1'b1;
  endtask

  // Issues one op, scrambles operands after the accept edge, counts busy cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel, output int n, output logic [31:0] first_hi);
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b1;
    bus.MDU_i_Op = op;
    bus.MDU_i_A = a;
    bus.MDU_i_B = b;
    bus.MDU_i_Cancel = cancel;
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b0;
    bus.MDU_i_Cancel = 1'b0;
    bus.MDU_i_A = ~a;
    bus.MDU_i_B = b ^ 32'h5A5A_5A5A;
    bus.MDU_i_RdHi = 1'b1;
    first_hi = bus.MDU_o_Out;
    n = 0;
    while (bus.MDU_o_Busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic preset(input logic [31:0] v);
    int n;
    logic [31:0] f;
    do_op(3'd5, v, 32'd0, 1'b0, n, f);
    do_op(3'd6, v, 32'd0, 1'b0, n, f);
  endtask

  initial begin
    int n;
    logic [31:0] f, hi, lo;

    bus.MDU_i_Start = 1'b0;
    bus.MDU_i_Op = 3'd0;
    bus.MDU_i_Cancel = 1'b0;
    bus.MDU_i_A = 32'd0;
    bus.MDU_i_B = 32'd0;
    bus.MDU_i_RdHi = 1'b1;

    add("mult_neg",   3'd1, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'h0000_0000, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    add("multu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    add("mult_7xm1",  3'd1, 32'd7,         32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF9);
    add("multu_2p32", 3'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'hAAAA_AAAA, 5,  32'h0000_0001, 32'h0000_0000);
    add("div_m7_2",   3'd3, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add("div_7_m2",   3'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    add("div_ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h1111_1111, 10, 32'h0000_0000, 32'h8000_0000);
    add("divu_100_7", 3'd4, 32'd100,       32'd7,        1'b0, 32'h0000_0000, 10, 32'h0000_0002, 32'h0000_000E);
    add("divu_by0",   3'd4, 32'd100,       32'd0,        1'b0, 32'h1234_5678, 10, 32'h1234_5678, 32'h1234_5678);
    add("div_by0",    3'd3, 32'hFFFF_FFF9, 32'd0,        1'b0, 32'h0BAD_F00D, 10, 32'h0BAD_F00D, 32'h0BAD_F00D);
    add("mthi_cancel",3'd5, 32'hDEAD_BEEF, 32'd0,        1'b1, 32'h1111_1111, 0,  32'h1111_1111, 32'h1111_1111);
    add("mthi",       3'd5, 32'hDEAD_BEEF, 32'd0,        1'b0, 32'h1111_1111, 0,  32'hDEAD_BEEF, 32'h1111_1111);
    add("mtlo",       3'd6, 32'hCAFE_F00D, 32'd0,        1'b0, 32'h1111_1111, 0,  32'h1111_1111, 32'hCAFE_F00D);
    add("mult_cancel",3'd1, 32'd6,         32'd7,        1'b1, 32'h2222_2222, 0,  32'h2222_2222, 32'h2222_2222);
    add("op0_nop",    3'd0, 32'd6,         32'd7,        1'b0, 32'h3333_3333, 0,  32'h3333_3333, 32'h3333_3333);
    add("op7_nop",    3'd7, 32'd6,         32'd7,        1'b0, 32'h4444_4444, 0,  32'h4444_4444, 32'h4444_4444);

    #2;
    read_hilo(hi, lo);
    check("reset_busy", {31'd0, bus.MDU_o_Busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      preset(vecs[i].pre);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cancel, n, f);
      check({vecs[i].name, "_busy_cycles"}, 32'(n), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0) check({vecs[i].name, "_old_hi_while_busy"}, f, vecs[i].pre);
      read_hilo(hi, lo);
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // Cancel raised while busy must not abort the in-flight multiply.
    preset(32'h9999_9999);
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b1; bus.MDU_i_Op = 3'd1; bus.MDU_i_A = 32'd6; bus.MDU_i_B = 32'd7;
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b0;
    bus.MDU_i_Cancel = 1'b1;
    n = 0;
    while (bus.MDU_o_Busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    bus.MDU_i_Cancel = 1'b0;
    read_hilo(hi, lo);
    check("cancel_busy_cycles", 32'(n), 32'd5);
    check("cancel_busy_hi", hi, 32'd0);
    check("cancel_busy_lo", lo, 32'd42);

    // Reset during the fourth busy cycle of a divide discards the result.
    preset(32'h5555_5555);
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b1; bus.MDU_i_Op = 3'd3; bus.MDU_i_A = 32'hFFFF_FFF9; bus.MDU_i_B = 32'd2;
    @(posedge clk); #1;
    bus.MDU_i_Start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_mid_busy_before", {31'd0, bus.MDU_o_Busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, bus.MDU_o_Busy}, 32'd0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
    end
    read_hilo(hi, lo);
    check("rst_after_busy", {31'd0, bus.MDU_o_Busy}, 32'd0);
    check("rst_after_hi", hi, 32'd0);
    check("rst_after_lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
